// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation phase: walks a pre-scheduled S box in
// s_mem and decrypts a length-prefixed ciphertext into plaintext memory.
module arc4_prga (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  s_addr,
   input  logic [7:0]  s_rddata,
   output logic [7:0]  s_wrdata,
   output logic        s_wren,
   output logic [7:0]  ct_addr,
   input  logic [7:0]  ct_rddata,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  pt_wrdata,
   output logic        pt_wren
);

   localparam logic [4:0] ST_INIT  = 5'd0;
   localparam logic [4:0] ST_IDLE  = 5'd1;
   localparam logic [4:0] RD_LEN_A = 5'd2;
   localparam logic [4:0] RD_LEN_S = 5'd3;
   localparam logic [4:0] WR_LEN   = 5'd4;
   localparam logic [4:0] RD_SI_A  = 5'd5;
   localparam logic [4:0] RD_SI_S  = 5'd6;
   localparam logic [4:0] RD_SJ_A  = 5'd7;
   localparam logic [4:0] RD_SJ_S  = 5'd8;
   localparam logic [4:0] WR_SI    = 5'd9;
   localparam logic [4:0] WR_SJ    = 5'd10;
   localparam logic [4:0] RD_PAD_A = 5'd11;
   localparam logic [4:0] RD_PAD_S = 5'd12;
   localparam logic [4:0] RD_CT_A  = 5'd13;
   localparam logic [4:0] RD_CT_S  = 5'd14;
   localparam logic [4:0] WR_PT    = 5'd15;
   localparam logic [4:0] ST_DONE  = 5'd16;

   logic [4:0] state_q, state_d;
   logic [7:0] i_q, i_d;
   logic [7:0] j_q, j_d;
   logic [7:0] k_q, k_d;
   logic [7:0] len_q, len_d;
   logic [7:0] si_q, si_d;
   logic [7:0] sj_q, sj_d;
   logic [7:0] pad_q, pad_d;
   logic [7:0] ct_q, ct_d;

   // key is consumed by the upstream scheduler; pt is write-only here
   logic unused_in;
   assign unused_in = ^{key, pt_rddata};

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      len_d   = len_q;
      si_d    = si_q;
      sj_d    = sj_q;
      pad_d   = pad_q;
      ct_d    = ct_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (en) begin
               i_d     = 8'd0;
               j_d     = 8'd0;
               k_d     = 8'd0;
               state_d = RD_LEN_A;
            end
         end
         RD_LEN_A: state_d = RD_LEN_S;
         RD_LEN_S: begin
            len_d   = ct_rddata;
            state_d = WR_LEN;
         end
         WR_LEN: begin
            if (len_q == 8'd0) begin
               state_d = ST_DONE;
            end else begin
               k_d     = 8'd1;
               i_d     = i_q + 8'd1;
               state_d = RD_SI_A;
            end
         end
         RD_SI_A: state_d = RD_SI_S;
         RD_SI_S: begin
            si_d    = s_rddata;
            j_d     = j_q + s_rddata;
            state_d = RD_SJ_A;
         end
         RD_SJ_A: state_d = RD_SJ_S;
         RD_SJ_S: begin
            sj_d    = s_rddata;
            state_d = WR_SI;
         end
         WR_SI:    state_d = WR_SJ;
         WR_SJ:    state_d = RD_PAD_A;
         RD_PAD_A: state_d = RD_PAD_S;
         RD_PAD_S: begin
            pad_d   = s_rddata;
            state_d = RD_CT_A;
         end
         RD_CT_A: state_d = RD_CT_S;
         RD_CT_S: begin
            ct_d    = ct_rddata;
            state_d = WR_PT;
         end
         WR_PT: begin
            if (k_q == len_q) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + 8'd1;
               i_d     = i_q + 8'd1;
               state_d = RD_SI_A;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Addresses are held through both the address and sample cycles
   always_comb begin
      rdy       = (state_q == ST_IDLE);
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      ct_addr   = 8'd0;
      pt_addr   = 8'd0;
      pt_wrdata = 8'd0;
      pt_wren   = 1'b0;
      case (state_q)
         RD_SI_A, RD_SI_S: s_addr = i_q;
         RD_SJ_A, RD_SJ_S: s_addr = j_q;
         WR_SI: begin
            s_addr   = i_q;
            s_wrdata = sj_q;
            s_wren   = 1'b1;
         end
         WR_SJ: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
         end
         RD_PAD_A, RD_PAD_S: s_addr = si_q + sj_q;
         RD_CT_A, RD_CT_S:   ct_addr = k_q;
         WR_LEN: begin
            pt_addr   = 8'd0;
            pt_wrdata = len_q;
            pt_wren   = 1'b1;
         end
         WR_PT: begin
            pt_addr   = k_q;
            pt_wrdata = ct_q ^ pad_q;
            pt_wren   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= ST_INIT;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         k_q     <= 8'd0;
         len_q   <= 8'd0;
         si_q    <= 8'd0;
         sj_q    <= 8'd0;
         pad_q   <= 8'd0;
         ct_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         pad_q   <= pad_d;
         ct_q    <= ct_d;
      end
   end

endmodule

// File: tb/tb_arc4_prga.sv
// Scoreboard bench for arc4_prga: models s_mem/ct/pt as registered-address
// RAMs and checks every plaintext write against a software ARC4 model.
module tb_arc4_prga;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  s_addr, s_rddata, s_wrdata;
   logic        s_wren;
   logic [7:0]  ct_addr, ct_rddata;
   logic [7:0]  pt_addr, pt_rddata, pt_wrdata;
   logic        pt_wren;

   logic [7:0] smem [256];
   logic [7:0] ctm  [256];
   logic [7:0] ptm  [256];
   logic [7:0] ms   [256];
   logic [7:0] s_addr_r, ct_addr_r, pt_addr_r;

   logic [15:0] q [$];
   int checks = 0;
   int errors = 0;
   int swr = 0;

   always #5 clk = ~clk;

   arc4_prga dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
      .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata),
      .s_wren(s_wren), .ct_addr(ct_addr), .ct_rddata(ct_rddata),
      .pt_addr(pt_addr), .pt_rddata(pt_rddata), .pt_wrdata(pt_wrdata),
      .pt_wren(pt_wren)
   );

   always @(posedge clk) begin
      if (s_wren) smem[s_addr] <= s_wrdata;
      if (pt_wren) ptm[pt_addr] <= pt_wrdata;
      s_addr_r  <= s_addr;
      ct_addr_r <= ct_addr;
      pt_addr_r <= pt_addr;
   end
   assign s_rddata  = smem[s_addr_r];
   assign ct_rddata = ctm[ct_addr_r];
   assign pt_rddata = ptm[pt_addr_r];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (s_wren) swr++;
      if (pt_wren) begin
         chk("pt_pending", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) chk("pt_wr", {pt_addr, pt_wrdata}, q.pop_front());
      end
   end

   task automatic ksa(input logic [23:0] kk);
      logic [7:0] j, t;
      logic [7:0] kb [3];
      kb[0] = kk[23:16];
      kb[1] = kk[15:8];
      kb[2] = kk[7:0];
      for (int n = 0; n < 256; n++) ms[n] = 8'(n);
      j = 8'd0;
      for (int n = 0; n < 256; n++) begin
         j = j + ms[n] + kb[n % 3];
         t = ms[n];
         ms[n] = ms[j];
         ms[j] = t;
      end
   endtask

   task automatic load_s();
      for (int n = 0; n < 256; n++) smem[n] = ms[n];
   endtask

   task automatic run(input int len, input bit poke);
      logic [7:0] i, j, si, sj, pad;
      int busy, diff;
      ctm[0] = 8'(len);
      q.push_back({8'd0, 8'(len)});
      i = 8'd0;
      j = 8'd0;
      for (int k = 1; k <= len; k++) begin
         i = i + 8'd1;
         si = ms[i];
         j = j + si;
         sj = ms[j];
         ms[i] = sj;
         ms[j] = si;
         pad = ms[8'(si + sj)];
         q.push_back({8'(k), ctm[k] ^ pad});
      end
      swr = 0;
      chk("rdy_idle", 64'(rdy), 64'd1);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      chk("rdy_fall", 64'(rdy), 64'd0);
      busy = 1;
      while (busy < 4000) begin
         @(negedge clk);
         if (rdy) break;
         busy++;
         en = poke && (busy == 4);
      end
      en = 1'b0;
      chk("rdy_ret", 64'(rdy), 64'd1);
      chk("latency", 64'(busy <= 12 * len + 8), 64'd1);
      chk("q_empty", 64'(q.size()), 64'd0);
      chk("s_wr_cnt", 64'(swr), 64'(2 * len));
      diff = 0;
      for (int n = 0; n < 256; n++) if (smem[n] !== ms[n]) diff++;
      chk("s_final", 64'(diff), 64'd0);
      @(negedge clk);
      chk("stay_idle", 64'(rdy), 64'd1);
      q.delete();
   endtask

   initial begin
      string msg;
      rst_n = 1'b1;
      en    = 1'b0;
      key   = 24'h000155;
      for (int n = 0; n < 256; n++) ctm[n] = 8'd0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("rst_out", {rdy, s_wren, pt_wren, s_addr, s_wrdata, ct_addr,
                         pt_addr, pt_wrdata}, 64'd0);
      end
      rst_n = 1'b0;
      #1;
      chk("rdy_pre", 64'(rdy), 64'd0);
      @(negedge clk);
      chk("rdy_up", 64'(rdy), 64'd1);

      ksa(key);
      load_s();
      msg = "attack at dawn, bring snacks";
      for (int n = 0; n < msg.len(); n++) ctm[n + 1] = msg[n];
      run(msg.len(), 1'b0);

      for (int n = 1; n <= 40; n++) ctm[n] = 8'($urandom_range(0, 255));
      run(40, 1'b1);

      run(0, 1'b1);

      for (int n = 1; n <= 255; n++) ctm[n] = 8'($urandom_range(0, 255));
      run(255, 1'b0);

      for (int n = 0; n < 256; n++) ms[n] = 8'(n);
      ms[0] = 8'd1;
      ms[1] = 8'd0;
      load_s();
      for (int n = 1; n <= 5; n++) ctm[n] = 8'(8'h30 + n);
      run(5, 1'b0);

      for (int n = 0; n < 256; n++) ms[n] = 8'(n);
      load_s();
      ctm[1] = 8'hA5;
      run(1, 1'b0);
      chk("s1_kept", 64'(smem[1]), 64'd1);
      for (int n = 1; n <= 6; n++) ctm[n] = 8'(8'h11 * n);
      run(6, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
